// File: rtl/cnn_fmap_reader_pkg.sv
// Shared types and sizing for the feature-map reader.
// Tile field widths follow the line buffer geometry.
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 16
`endif
`ifndef BUFFER_DEPTH
`define BUFFER_DEPTH 16
`endif

package cnn_fmap_reader_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int W_BITS_DEF  = $clog2(`BUFFER_WIDTH);
    localparam int D_BITS_DEF  = $clog2(`BUFFER_DEPTH);
    localparam int MAX_OUT_DEF = 4;
endpackage

// File: rtl/cnn_fmap_reader_if.sv
// lacc command/response stream plus the feature-map SRAM read port.
// slave = the reader block, master = line buffer / SRAM side.
interface cnn_fmap_reader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  lacc_data_valid;
    logic                  lacc_data_ready;
    logic                  lacc_drsp_valid;
    logic [DATA_WIDTH-1:0] lacc_drsp_rdata;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  lacc_data_valid, mem_gnt, mem_rvalid, mem_rdata,
        output lacc_data_ready, lacc_drsp_valid, lacc_drsp_rdata, mem_req, mem_addr
    );
    modport master (
        output lacc_data_valid, mem_gnt, mem_rvalid, mem_rdata,
        input  lacc_data_ready, lacc_drsp_valid, lacc_drsp_rdata, mem_req, mem_addr
    );
endinterface

// File: rtl/cnn_fmap_reader_addr_gen.sv
// Row-major tile walker: x/y counters and row base, advanced once per accepted read.
module fmap_addr_gen
    import cnn_fmap_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int W_BITS     = W_BITS_DEF,
    parameter int D_BITS     = D_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  adv,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] row_pitch,
    input  logic [W_BITS-1:0]     tile_width,
    input  logic [D_BITS-1:0]     tile_depth,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);
    logic [W_BITS-1:0]     x, tw_q;
    logic [D_BITS-1:0]     y, td_q;
    logic [ADDR_WIDTH-1:0] row_base, pitch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            tw_q     <= '0;
            td_q     <= '0;
            row_base <= '0;
            pitch_q  <= '0;
        end else if (load) begin
            x        <= '0;
            y        <= '0;
            tw_q     <= tile_width;
            td_q     <= tile_depth;
            row_base <= base_addr;
            pitch_q  <= row_pitch;
        end else if (adv) begin
            if (x == tw_q) begin
                x        <= '0;
                y        <= y + D_BITS'(1);
                row_base <= row_base + pitch_q;
            end else begin
                x <= x + W_BITS'(1);
            end
        end
    end

    // Address arithmetic wraps modulo 2^ADDR_WIDTH by construction.
    assign addr = row_base + ADDR_WIDTH'(x);
    assign last = (x == tw_q) && (y == td_q);
endmodule

// File: rtl/cnn_fmap_reader.sv
// Memory-side responder for the lacc read stream: one SRAM read per accepted
// command, walking one tile in row-major order, data returned in order.
module cnn_fmap_reader
    import cnn_fmap_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int W_BITS     = W_BITS_DEF,
    parameter int D_BITS     = D_BITS_DEF,
    parameter int MAX_OUT    = MAX_OUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] row_pitch_i,
    input  logic [W_BITS-1:0]     tile_width_i,
    input  logic [D_BITS-1:0]     tile_depth_i,
    cnn_fmap_reader_if.slave      bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int CW = $clog2(MAX_OUT) + 1;

    state_t                state, state_nxt;
    logic [CW-1:0]         out_cnt;
    logic                  load, accept, rsp_ok, last, ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  drsp_valid;
    logic [DATA_WIDTH-1:0] drsp_rdata;

    assign ready  = (state == ISSUE) && bus.mem_gnt && (out_cnt < CW'(MAX_OUT));
    assign accept = bus.lacc_data_valid && ready;
    // A return with nothing outstanding is stray (e.g. survived a reset) and is dropped.
    assign rsp_ok = bus.mem_rvalid && (out_cnt != '0);

    assign bus.lacc_data_ready = ready;
    assign bus.mem_req         = accept;
    assign bus.mem_addr        = mem_addr;
    assign bus.lacc_drsp_valid = drsp_valid;
    assign bus.lacc_drsp_rdata = drsp_rdata;
    assign busy                = (state != IDLE);

    fmap_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .W_BITS    (W_BITS),
        .D_BITS    (D_BITS)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .adv       (accept),
        .base_addr (base_addr_i),
        .row_pitch (row_pitch_i),
        .tile_width(tile_width_i),
        .tile_depth(tile_depth_i),
        .addr      (mem_addr),
        .last      (last)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                state_nxt = ISSUE;
                load      = 1'b1;
            end
            ISSUE: if (accept && last) state_nxt = DRAIN;
            DRAIN: if (out_cnt == '0) begin
                state_nxt = IDLE;
                done      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_cnt    <= '0;
            err        <= 1'b0;
            drsp_valid <= 1'b0;
            drsp_rdata <= '0;
        end else begin
            state <= state_nxt;
            unique case ({accept, rsp_ok})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                2'b01:   out_cnt <= out_cnt - CW'(1);
                default: out_cnt <= out_cnt;
            endcase
            if (bus.mem_rvalid && (out_cnt == '0)) err <= 1'b1;
            drsp_valid <= rsp_ok;
            if (rsp_ok) drsp_rdata <= bus.mem_rdata;
        end
    end
endmodule

// File: doc/cnn_fmap_reader.md
# cnn_fmap_reader

Memory-side responder for the line buffer's lacc read stream. Each accepted `lacc_data_valid`/`lacc_data_ready` command is turned into one feature-map SRAM read at an internally generated address, in row-major tile order. The read data is returned in order on `lacc_drsp_valid`/`lacc_drsp_rdata`. The block sits between the feature-map SRAM and the window generator, and owns all address arithmetic for one tile.

## Interface
- ADDR_WIDTH, 32, SRAM word address width
- DATA_WIDTH, 32, word width; matches lacc rdata
- W_BITS, $clog2(`BUFFER_WIDTH), tile width field width
- D_BITS, $clog2(`BUFFER_DEPTH), tile depth field width
- MAX_OUT, 4, maximum outstanding SRAM reads (power of two)

- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  begin a tile; sampled in IDLE only
- base_addr_i  in  ADDR_WIDTH  word address of tile element (0,0)
- row_pitch_i  in  ADDR_WIDTH  word distance between tile rows
- tile_width_i  in  W_BITS  last column index (row holds tile_width_i+1 words)
- tile_depth_i  in  D_BITS  last row index (tile holds tile_depth_i+1 rows)
- lacc_data_valid  in  1  read command from line buffer
- lacc_data_ready  out  1  command accepted when both high
- lacc_drsp_valid  out  1  response word valid (no backpressure)
- lacc_drsp_rdata  out  DATA_WIDTH  response word
- mem_req  out  1  SRAM read request
- mem_addr  out  ADDR_WIDTH  SRAM word address
- mem_gnt  in  1  SRAM accepts request this cycle; independent of mem_req
- mem_rvalid  in  1  SRAM read data valid; in order, latency ≥1
- mem_rdata  in  DATA_WIDTH  SRAM read data
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when the tile is complete
- err  out  1  sticky: mem_rvalid received with zero outstanding

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE→ISSUE on `start`. Latch all `_i` fields. Set x=0, y=0, row_base=base_addr_i, out_cnt=0.
- `lacc_data_ready` = ISSUE & mem_gnt & (out_cnt < MAX_OUT). It is combinational from registered state and mem_gnt only.
- `mem_req` = lacc_data_valid & lacc_data_ready. `mem_addr` = row_base + x (ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH).
- On accept:
  - if x==tile_width: x←0, y←y+1, row_base←row_base+row_pitch.
  - otherwise x←x+1.
- The last accept is the one at x==tile_width & y==tile_depth. It moves ISSUE→DRAIN. After it, ready stays low.
- out_cnt updates: +1 on accept, −1 on mem_rvalid, unchanged when both occur.
- mem_rvalid when out_cnt==0: set err and drop the data; out_cnt holds at 0.
- DRAIN→IDLE when out_cnt==0. `done` pulses in that transition cycle.
- `start` in ISSUE/DRAIN is ignored. Commands in IDLE/DRAIN are never accepted.
- Total responses per tile = (tile_width_i+1)·(tile_depth_i+1).

## Timing
- Reset values: lacc_data_ready=0, lacc_drsp_valid=0, lacc_drsp_rdata=0, mem_req=0, busy=0, done=0, err=0, state=IDLE.
- A `rst` during ISSUE/DRAIN abandons the tile. In-flight SRAM returns after reset increment nothing and set err.
- Response latency: lacc_drsp_valid/rdata are registered copies of mem_rvalid/mem_rdata, so they appear one cycle after mem_rvalid.
- Throughput: one command per cycle while mem_gnt=1 and the SRAM round trip ≤ MAX_OUT cycles.
- `done` coincides with the cycle after the final mem_rvalid, i.e. the same cycle as the final lacc_drsp_valid.
- 1×1 tile: start at t0; ISSUE at t1; accept at t1 → DRAIN.

## Structure
- Shared package/header holds:
  - state encodings IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2;
  - tile_width/tile_depth field widths derived from `BUFFER_WIDTH/`BUFFER_DEPTH;
  - MAX_OUT default.
- One natural sub-module: `fmap_addr_gen`. It holds the x/y counters, row_base, the last-element flag and the mem_addr output, advanced by an `adv` strobe.
- Outstanding counter, FSM and response register stay in the top.

## Test plan
- Tile 4×3 (tile_width_i=3, tile_depth_i=2), base 0x100, pitch 16, mem_gnt=1, latency 2, valid held high → expect:
  - 12 accepts with addresses 0x100–0x103, 0x110–0x113, 0x120–0x123;
  - 12 in-order responses;
  - done in the cycle of the 12th drsp_valid.
- Same tile, SRAM latency 8, MAX_OUT=4 → ready drops after 4 outstanding; at most 4 in flight; all 12 returned.
- mem_gnt toggled 1010…, lacc_data_valid random → no accept while mem_gnt=0; address sequence unchanged.
- 1×1 tile, base 0xFFFFFFFF, pitch 1 → single read at 0xFFFFFFFF; done after one response. Then a 2×2 tile at base 0xFFFFFFFE, pitch 1 → addresses FFFFFFFE, FFFFFFFF, FFFFFFFF, 00000000 (wrap).
- rst asserted mid-ISSUE after 5 accepts, with 2 reads still returning → outputs at reset values next cycle; the stray mem_rvalid sets err=1; no drsp_valid.
- start pulsed during DRAIN, and mem_rvalid coinciding with an accept → start ignored; out_cnt unchanged on the coincident cycle; done exactly once.
